// File: rtl/bp_initiator.sv
// rtl/bp_initiator.sv - BytePipe host initiator: register requests to command bytes, response bytes back
// One transaction in flight; burst reads first program the target burst counter at address 0.
module bp_initiator #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_cg,
  input  logic       i_req_valid,
  output logic       o_req_ready,
  input  logic       i_req_wr,
  input  logic [6:0] i_req_addr,
  input  logic [7:0] i_req_wdata,
  input  logic [7:0] i_req_len,
  output logic [7:0] o_bp_data,
  output logic       o_bp_valid,
  input  logic       i_bp_ready,
  input  logic [7:0] i_bp_data,
  input  logic       i_bp_valid,
  output logic       o_bp_ready,
  output logic [7:0] o_rsp_data,
  output logic       o_rsp_valid,
  output logic       o_rsp_last,
  input  logic       i_rsp_ready,
  output logic       o_timeout,
  output logic       o_busy
);

  localparam bit TO_EN = (TIMEOUT_CYCLES > 0);
  localparam int TW = TO_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TO_EN ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [2:0] {
    IDLE, SETLEN_CMD, SETLEN_DATA, SETLEN_RSP, CMD, WDATA, RSP
  } stateT;

  stateT         state, stateNext;
  logic          reqWr;
  logic [6:0]    reqAddr;
  logic [7:0]    reqWdata, reqLen;
  logic [7:0]    remaining, remainingNext;
  logic [TW-1:0] toCnt, toCntNext;
  logic          timeoutQ;

  logic          txValid, rxReady, inRx;
  logic [7:0]    txByte;
  logic          txFire, rxFire, reqFire, toHit;

  always_comb begin
    txValid = 1'b0;
    rxReady = 1'b0;
    inRx    = 1'b0;
    txByte  = 8'h00;
    case (state)
      SETLEN_CMD:  begin txValid = 1'b1; txByte = 8'h80; end
      SETLEN_DATA: begin txValid = 1'b1; txByte = reqLen; end
      CMD:         begin txValid = 1'b1; txByte = {reqWr, reqAddr}; end
      WDATA:       begin txValid = 1'b1; txByte = reqWdata; end
      SETLEN_RSP:  begin inRx = 1'b1; rxReady = 1'b1; end
      RSP:         begin inRx = 1'b1; rxReady = i_rsp_ready; end
      default:     ;
    endcase
  end

  assign txFire  = txValid && i_bp_ready && i_cg;
  assign rxFire  = rxReady && i_bp_valid && i_cg;
  assign reqFire = (state == IDLE) && i_req_valid && i_cg;
  // Requester back-pressure in RSP still ages the transaction.
  assign toHit   = TO_EN && inRx && i_cg && !rxFire && (toCnt == TO_LAST);

  always_comb begin
    stateNext     = state;
    remainingNext = remaining;
    toCntNext     = toCnt;
    case (state)
      IDLE:        if (reqFire) stateNext = (!i_req_wr && i_req_len != '0) ? SETLEN_CMD : CMD;
      SETLEN_CMD:  if (txFire) stateNext = SETLEN_DATA;
      SETLEN_DATA: if (txFire) begin stateNext = SETLEN_RSP; toCntNext = '0; end
      SETLEN_RSP:  if (rxFire) stateNext = CMD;
      CMD: begin
        if (txFire) begin
          if (reqWr) begin
            stateNext = WDATA;
          end else begin
            stateNext     = RSP;
            remainingNext = reqLen;
            toCntNext     = '0;
          end
        end
      end
      WDATA: if (txFire) begin stateNext = RSP; remainingNext = '0; toCntNext = '0; end
      RSP: begin
        if (rxFire) begin
          if (remaining == '0) stateNext = IDLE;
          else remainingNext = remaining - 1'b1;
        end
      end
      default: stateNext = IDLE;
    endcase
    if (inRx) begin
      if (rxFire) begin
        toCntNext = '0;
      end else if (toHit) begin
        stateNext     = IDLE;
        remainingNext = '0;
        toCntNext     = '0;
      end else if (TO_EN && i_cg) begin
        toCntNext = toCnt + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state     <= IDLE;
      remaining <= '0;
      toCnt     <= '0;
      timeoutQ  <= 1'b0;
      reqWr     <= 1'b0;
      reqAddr   <= '0;
      reqWdata  <= '0;
      reqLen    <= '0;
    end else if (i_cg) begin
      state     <= stateNext;
      remaining <= remainingNext;
      toCnt     <= toCntNext;
      timeoutQ  <= toHit;
      if (reqFire) begin
        reqWr    <= i_req_wr;
        reqAddr  <= i_req_addr;
        reqWdata <= i_req_wdata;
        reqLen   <= i_req_len;
      end
    end
  end

  assign o_req_ready = (state == IDLE) && i_cg;
  assign o_bp_valid  = txValid && i_cg;
  assign o_bp_data   = txByte;
  assign o_bp_ready  = rxReady && i_cg;
  assign o_rsp_valid = (state == RSP) && i_bp_valid && i_cg;
  assign o_rsp_data  = (state == RSP) ? i_bp_data : 8'h00;
  assign o_rsp_last  = (state == RSP) && (remaining == '0);
  assign o_timeout   = timeoutQ;
  assign o_busy      = (state != IDLE);

endmodule

// File: doc/bp_initiator.md
Name: bp_initiator

Overview:
- Host-side BytePipe initiator.
- Turns single-word register requests into the BytePipe command byte stream for a register-map target (e.g. the correlator's register block), and returns the target's response bytes to the requester.
- Supports single read, single write and burst read. Burst read works by first writing the burst count to address 0, then issuing the read.
- Sits between a test/host engine (or a UART/USB bridge) and the target; one outstanding transaction at a time; per-transaction response timeout.

Parameters:
- TIMEOUT_CYCLES, 1024: consecutive cycles without a response byte before a transaction is abandoned; 0 disables the timeout.

Ports:
- i_clk  input  1  clock
- i_rst_n  input  1  synchronous active-low reset
- i_cg  input  1  clock-gate enable; when 0 all registers hold and o_req_ready, o_bp_valid, o_bp_ready, o_rsp_valid are forced 0
- i_req_valid  input  1  request valid
- o_req_ready  output  1  request ready (IDLE only)
- i_req_wr  input  1  1=write, 0=read
- i_req_addr  input  7  target register address
- i_req_wdata  input  8  write data (writes only)
- i_req_len  input  8  read burst length minus 1; 0=single; ignored for writes
- o_bp_data  output  8  byte to target
- o_bp_valid  output  1  byte to target valid
- i_bp_ready  input  1  target accepts byte
- i_bp_data  input  8  response byte from target
- i_bp_valid  input  1  response byte valid
- o_bp_ready  output  1  initiator accepts response byte
- o_rsp_data  output  8  response byte to requester
- o_rsp_valid  output  1  response valid
- o_rsp_last  output  1  final response byte of the transaction
- i_rsp_ready  input  1  requester accepts response
- o_timeout  output  1  one-cycle pulse: transaction abandoned
- o_busy  output  1  state != IDLE

Behaviour:
- Protocol, target side:
  - Command byte = {wr, addr[6:0]}.
  - Write = command byte then one data byte; the target returns exactly 1 byte (pre-write register value).
  - Read = command byte; the target returns 1 byte, or L bytes if the burst counter was set to L-1 by a write to address 0.
- Handshakes: byte transfers when valid && ready (&& i_cg). The tx byte and valid stay stable until accepted.
- Request capture:
  - On i_req_valid && o_req_ready, capture wr, addr, wdata, len into registers.
  - State moves on the next edge, so the first tx byte is valid the cycle after acceptance.
- FSM states and transitions:
  - IDLE: o_req_ready=1. On accept: go to SETLEN_CMD if read and len!=0; otherwise go to CMD.
  - SETLEN_CMD: send 0x80. On accept, go to SETLEN_DATA.
  - SETLEN_DATA: send len. On accept, go to SETLEN_RSP.
  - SETLEN_RSP: o_bp_ready=1. Accept 1 byte, discard it (not forwarded), go to CMD.
  - CMD: send {wr, addr}. On accept: go to WDATA if wr; otherwise go to RSP with remaining=len.
  - WDATA: send wdata. On accept, go to RSP with remaining=0.
  - RSP:
    - o_rsp_valid=i_bp_valid, o_rsp_data=i_bp_data, o_bp_ready=i_rsp_ready (combinational passthrough, zero latency).
    - o_rsp_last=(remaining==0).
    - Each accepted byte: if remaining==0 go to IDLE, else remaining-1.
- Outputs outside their states: o_bp_valid=0 outside SETLEN_CMD/SETLEN_DATA/CMD/WDATA; o_bp_ready=0 outside SETLEN_RSP/RSP, so stray rx bytes are held off, never dropped.
- Total bytes returned:
  - burst read: len+1 bytes;
  - single read or write: 1 byte, with o_rsp_last=1.
- Timeout counter:
  - Width $clog2(TIMEOUT_CYCLES+1). Cleared on entering SETLEN_RSP/RSP and on every accepted rx byte.
  - Increments each i_cg cycle in those states with no rx byte accepted. Stalls caused by i_rsp_ready=0 while i_bp_valid=1 also count.
  - On reaching TIMEOUT_CYCLES: go to IDLE, pulse o_timeout for 1 cycle, discard remaining count.
  - No increment when TIMEOUT_CYCLES=0.
- Tx stalls (i_bp_ready=0) do not count toward the timeout.
- Reset values: state IDLE, counter 0, remaining 0; o_req_ready=1 (when i_cg=1); o_bp_valid=0, o_bp_ready=0, o_rsp_valid=0, o_rsp_last=0, o_timeout=0, o_busy=0.
- Reset mid-transaction: return to IDLE on the next edge; nothing further is sent.
- i_rsp_ready is only sampled in RSP; a requester asserting it early has no effect.
- Request arriving while busy: held off (o_req_ready=0) until IDLE.

Test Plan:
- Single read addr 0x04, target returns 0x20 → tx bytes [0x04]; rsp 0x20 with last=1; o_busy falls the cycle after.
- Single write addr 0x09 data 0x05, target returns 0x00 → tx [0x89,0x05]; rsp 0x00 with last=1.
- Burst read addr 0x01 len=3, target returns ack 0x00 then 0xA0..0xA3 → tx [0x80,0x03,0x01]; ack not forwarded; 4 rsp bytes, last only on 0xA3.
- Random i_bp_ready and i_rsp_ready gaps on the burst above → byte order and values unchanged; o_bp_data stable while stalled; no byte lost or duplicated.
- TIMEOUT_CYCLES=16, read issued, target silent → o_timeout pulses exactly 16 cycles after CMD acceptance; then o_req_ready=1; a second read completes normally.
- Assert i_rst_n=0 for 1 cycle mid-burst (after 2 of 4 bytes) → next cycle IDLE with all outputs at reset values; i_cg=0 for 5 cycles mid-CMD → o_bp_valid=0, state frozen, resumes identically.
